// File: rtl/knn_dist_gen_if.sv
// Insert-side and dataset-memory bus of the KNN distance generator.
// The generator is the master: it drives the read port of the dataset
// memory and pushes {datap_id, dist_entry} entries into the neighbour list.
interface knn_dist_gen_if #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 16,
  parameter int ID_W    = 8
);
  logic [ID_W-1:0]      mem_addr;
  logic                 mem_en;
  logic [2*COORD_W-1:0] mem_rdata;
  logic                 ready;
  logic                 list_clr;
  logic                 valid;
  logic [ID_W-1:0]      datap_id;
  logic [DATA_W-1:0]    dist_entry;

  modport master (
    output mem_addr, mem_en, list_clr, valid, datap_id, dist_entry,
    input  mem_rdata, ready
  );

  modport slave (
    input  mem_addr, mem_en, list_clr, valid, datap_id, dist_entry,
    output mem_rdata, ready
  );
endinterface

// File: rtl/knn_dist_gen.sv
// Distance-generation front end for the KNN accelerator.
// Walks nbr_points dataset entries, computes the squared Euclidean distance
// to a latched test point and emits one saturated entry per point, in
// address order, to the sorted neighbour list.
module knn_dist_gen #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 16,
  parameter int ID_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] test_x,
  input  logic signed [COORD_W-1:0] test_y,
  input  logic [ID_W-1:0]           nbr_points,
  output logic                      busy,
  output logic                      done,
  knn_dist_gen_if.master            bus
);

  localparam int DIFF_W = COORD_W + 1;
  localparam int SQ_W   = 2 * COORD_W + 2;
  localparam int SUM_W  = 2 * COORD_W + 3;
  // All-ones is the list's empty marker, so the largest legal distance is one below it.
  localparam logic [DATA_W-1:0] DIST_SAT = {{(DATA_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_WAIT,
    S_CALC,
    S_EMIT,
    S_FIN
  } state_t;

  state_t                    state_q;
  logic signed [COORD_W-1:0] tx_q;
  logic signed [COORD_W-1:0] ty_q;
  logic [ID_W-1:0]           nbr_q;
  logic [ID_W-1:0]           idx_q;
  logic signed [DIFF_W-1:0]  dx_q;
  logic signed [DIFF_W-1:0]  dy_q;
  logic [ID_W-1:0]           mem_addr_q;
  logic                      mem_en_q;
  logic                      list_clr_q;
  logic                      valid_q;
  logic [ID_W-1:0]           datap_id_q;
  logic [DATA_W-1:0]         dist_q;
  logic                      busy_q;
  logic                      done_q;

  logic signed [COORD_W-1:0] rx;
  logic signed [COORD_W-1:0] ry;
  logic signed [DIFF_W-1:0]  dx_d;
  logic signed [DIFF_W-1:0]  dy_d;
  logic signed [SQ_W-1:0]    dx_ext;
  logic signed [SQ_W-1:0]    dy_ext;
  logic signed [SQ_W-1:0]    sq_x;
  logic signed [SQ_W-1:0]    sq_y;
  logic [SUM_W-1:0]          sum_d;
  logic [DATA_W-1:0]         dist_d;
  logic [ID_W-1:0]           idx_inc;

  // Distance datapath: differences from the memory word, squares and saturation.
  always_comb begin
    rx      = bus.mem_rdata[COORD_W-1:0];
    ry      = bus.mem_rdata[2*COORD_W-1:COORD_W];
    dx_d    = {tx_q[COORD_W-1], tx_q} - {rx[COORD_W-1], rx};
    dy_d    = {ty_q[COORD_W-1], ty_q} - {ry[COORD_W-1], ry};
    dx_ext  = SQ_W'(dx_q);
    dy_ext  = SQ_W'(dy_q);
    // Squares are non-negative and fit in SQ_W bits, so treat them as unsigned.
    sq_x    = dx_ext * dx_ext;
    sq_y    = dy_ext * dy_ext;
    sum_d   = {1'b0, $unsigned(sq_x)} + {1'b0, $unsigned(sq_y)};
    dist_d  = (sum_d > SUM_W'(DIST_SAT)) ? DIST_SAT : sum_d[DATA_W-1:0];
    idx_inc = idx_q + 1'b1;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      ty_q       <= '0;
      nbr_q      <= '0;
      idx_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      list_clr_q <= 1'b0;
      valid_q    <= 1'b0;
      datap_id_q <= '0;
      dist_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      list_clr_q <= 1'b0;
      done_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_q       <= test_x;
            ty_q       <= test_y;
            nbr_q      <= nbr_points;
            idx_q      <= '0;
            list_clr_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (nbr_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end else begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= idx_q;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          dx_q    <= dx_d;
          dy_q    <= dy_d;
          state_q <= S_CALC;
        end
        S_CALC: begin
          dist_q     <= dist_d;
          datap_id_q <= idx_q;
          valid_q    <= 1'b1;
          state_q    <= S_EMIT;
        end
        S_EMIT: begin
          // Entry stays frozen until the list accepts it.
          if (bus.ready) begin
            valid_q <= 1'b0;
            idx_q   <= idx_inc;
            if (idx_inc == nbr_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FIN;
            end else begin
              mem_en_q   <= 1'b1;
              mem_addr_q <= idx_inc;
              state_q    <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.list_clr   = list_clr_q;
  assign bus.valid      = valid_q;
  assign bus.datap_id   = datap_id_q;
  assign bus.dist_entry = dist_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_knn_dist_gen.sv
// Directed testbench for knn_dist_gen: a synchronous-read dataset memory,
// a negedge monitor recording list transfers and pulses, and a linear
// sequence of directed passes with hand-computed expectations.
module tb_knn_dist_gen;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] test_x;
  logic signed [15:0] test_y;
  logic [7:0]         nbr_points;
  logic               busy;
  logic               done;

  knn_dist_gen_if #(.DATA_W(32), .COORD_W(16), .ID_W(8)) bus ();

  knn_dist_gen #(.DATA_W(32), .COORD_W(16), .ID_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .test_x     (test_x),
    .test_y     (test_y),
    .nbr_points (nbr_points),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] mem [0:255];

  int          tr_id   [$];
  logic [31:0] tr_dist [$];
  int          tr_cyc  [$];
  int          clr_cnt  = 0;
  int          clr_cyc  = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cnt = 0;
  int          men_cnt  = 0;

  int          exp_c [3] = '{2, 8, 0};
  int          exp_f [4] = '{2, 8, 0, 50};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read dataset memory.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid && bus.ready) begin
        tr_id.push_back(int'(bus.datap_id));
        tr_dist.push_back(bus.dist_entry);
        tr_cyc.push_back(cyc);
      end
      if (bus.list_clr) begin
        clr_cnt <= clr_cnt + 1;
        clr_cyc <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (bus.mem_en) men_cnt <= men_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pt(input int x, input int y);
    logic [15:0] xs;
    logic [15:0] ys;
    xs = x[15:0];
    ys = y[15:0];
    return {ys, xs};
  endfunction

  // Start pulse; t0 is the cycle in which start is high.
  task automatic do_start(input int tx, input int ty, input int n, output int t0);
    @(posedge clk); #1;
    test_x     = tx[15:0];
    test_y     = ty[15:0];
    nbr_points = n[7:0];
    start      = 1'b1;
    t0         = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max, input string tag);
    int k;
    k = 0;
    while (done_cnt == base && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt != base, 1);
  endtask

  task automatic wait_valid(input int max, input string tag);
    int k;
    k = 0;
    while (!bus.valid && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_valid_seen"}, bus.valid, 1);
  endtask

  initial begin
    int t0, n0, d0, c0, b0, m0, mh;
    logic [31:0] held_dist;

    rst        = 1'b1;
    start      = 1'b0;
    test_x     = '0;
    test_y     = '0;
    nbr_points = '0;
    bus.ready  = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, done, bus.valid, bus.mem_en, bus.list_clr}, 0);
    chk("rst_data", {bus.mem_addr, bus.datap_id, bus.dist_entry}, 0);
    rst = 1'b0;
    $display("[TB] reset released");

    // (3,4) against origin, N=1.
    mem[0] = pt(0, 0);
    n0 = tr_id.size(); d0 = done_cnt; c0 = clr_cnt;
    do_start(3, 4, 1, t0);
    wait_done(d0, 40, "a");
    @(posedge clk); #1;
    chk("a_clr_count", clr_cnt - c0, 1);
    chk("a_clr_cycle", clr_cyc, t0 + 1);
    chk("a_entries", tr_id.size() - n0, 1);
    chk("a_valid_cycle", tr_cyc[n0], t0 + 5);
    chk("a_id", tr_id[n0], 0);
    chk("a_dist", tr_dist[n0], 25);
    chk("a_done_cycle", done_cyc, t0 + 6);
    chk("a_done_count", done_cnt - d0, 1);
    $display("[TB] pass A: id=%0d dist=%0d", tr_id[n0], tr_dist[n0]);

    // Saturation: sum 8589672450 clamps below the empty marker.
    mem[0] = pt(-32768, -32768);
    n0 = tr_id.size(); d0 = done_cnt;
    do_start(32767, 32767, 1, t0);
    wait_done(d0, 40, "b");
    chk("b_dist_sat", tr_dist[n0], 32'hFFFF_FFFE);
    $display("[TB] pass B: dist=%0h", tr_dist[n0]);

    // N=3 streaming with ready high.
    mem[0] = pt(1, 1); mem[1] = pt(2, 2); mem[2] = pt(0, 0);
    n0 = tr_id.size(); d0 = done_cnt; b0 = busy_cnt;
    do_start(0, 0, 3, t0);
    wait_done(d0, 60, "c");
    @(posedge clk); #1;
    chk("c_entries", tr_id.size() - n0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("c_id", tr_id[n0+i], i);
      chk("c_dist", tr_dist[n0+i], exp_c[i]);
      chk("c_cycle", tr_cyc[n0+i], t0 + 5 + 4*i);
      $display("[TB] pass C entry: id=%0d dist=%0d", tr_id[n0+i], tr_dist[n0+i]);
    end
    // Busy covers CLEAR plus four cycles per point; start..done spans 15 cycles.
    chk("c_busy_cycles", busy_cnt - b0, 13);
    chk("c_done_cycle", done_cyc, t0 + 14);

    // N=2 with back-pressure on the first entry.
    mem[0] = pt(1, 2); mem[1] = pt(-3, 4);
    bus.ready = 1'b0;
    n0 = tr_id.size(); d0 = done_cnt; m0 = men_cnt;
    do_start(0, 0, 2, t0);
    wait_valid(20, "d");
    mh = men_cnt;
    held_dist = bus.dist_entry;
    chk("d_first_dist", held_dist, 5);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("d_hold", {bus.valid, bus.datap_id, bus.dist_entry}, {1'b1, 8'd0, 32'd5});
    end
    chk("d_no_extra_mem_en", men_cnt - mh, 0);
    bus.ready = 1'b1;
    wait_done(d0, 40, "d");
    chk("d_entries", tr_id.size() - n0, 2);
    chk("d_id1", tr_id[n0+1], 1);
    chk("d_dist1", tr_dist[n0+1], 25);
    chk("d_spacing", tr_cyc[n0+1] - tr_cyc[n0], 4);
    chk("d_mem_reads", men_cnt - m0, 2);
    $display("[TB] pass D: ids %0d,%0d dists %0d,%0d", tr_id[n0], tr_id[n0+1], tr_dist[n0], tr_dist[n0+1]);

    // N=0: clear then done, no entries.
    n0 = tr_id.size(); d0 = done_cnt;
    do_start(7, 7, 0, t0);
    wait_done(d0, 20, "e");
    chk("e_clr_cycle", clr_cyc, t0 + 1);
    chk("e_done_cycle", done_cyc, t0 + 2);
    chk("e_no_entries", tr_id.size() - n0, 0);
    $display("[TB] pass E: done at +%0d", done_cyc - t0);

    // N=4 with a stray start mid-pass and another on the done cycle.
    mem[0] = pt(1, 1); mem[1] = pt(2, 2); mem[2] = pt(0, 0); mem[3] = pt(5, -5);
    n0 = tr_id.size(); d0 = done_cnt;
    do_start(0, 0, 4, t0);
    @(posedge clk); #1;
    test_x = 16'sd100; nbr_points = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40 && cyc < t0 + 18; k++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("f_done_count", done_cnt - d0, 1);
    chk("f_done_cycle", done_cyc, t0 + 18);
    chk("f_idle_after", busy, 0);
    chk("f_entries", tr_id.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("f_id", tr_id[n0+i], i);
      chk("f_dist", tr_dist[n0+i], exp_f[i]);
      $display("[TB] pass F entry: id=%0d dist=%0d", tr_id[n0+i], tr_dist[n0+i]);
    end

    // Asynchronous reset while an entry is stalled.
    mem[0] = pt(1, 1);
    bus.ready = 1'b0;
    d0 = done_cnt;
    do_start(0, 0, 1, t0);
    wait_valid(20, "g");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("g_async_ctrl", {busy, done, bus.valid, bus.mem_en, bus.list_clr}, 0);
    chk("g_async_data", {bus.mem_addr, bus.datap_id, bus.dist_entry}, 0);
    @(posedge clk); #1;
    bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("g_no_done", done_cnt - d0, 0);
    $display("[TB] pass G: reset mid-pass");

    // Normal pass after the aborted one.
    mem[0] = pt(0, 0);
    n0 = tr_id.size(); d0 = done_cnt;
    do_start(3, 4, 1, t0);
    wait_done(d0, 40, "h");
    chk("h_entries", tr_id.size() - n0, 1);
    chk("h_dist", tr_dist[n0], 25);
    chk("h_done_cycle", done_cyc, t0 + 6);
    $display("[TB] pass H: id=%0d dist=%0d", tr_id[n0], tr_dist[n0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
